// File: rtl/secure_reg_requester.sv
// Initiator front end for the thread-gated secure register: admits only thread 0, serializes
// accesses onto the register bus, and counts denials. Optional lockout: define SECREG_LOCKOUT_EN.
module secure_reg_requester #(
  parameter int DATA_WIDTH     = 32,
  parameter int TID_WIDTH      = 4,
  parameter int VIOL_CNT_WIDTH = 8,
  parameter int LOCK_THRESHOLD = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [TID_WIDTH-1:0]      req_tid,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_denied,
  output logic                      reg_access_en,
  output logic                      reg_wr_en,
  output logic [TID_WIDTH-1:0]      reg_thread_id,
  output logic [DATA_WIDTH-1:0]     reg_data_in,
  input  logic [DATA_WIDTH-1:0]     reg_data_out,
  output logic [VIOL_CNT_WIDTH-1:0] viol_count,
  output logic                      viol_flag,
  output logic                      locked
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t                    state, state_next;
  logic                      lat_wr;
  logic [TID_WIDTH-1:0]      lat_tid;
  logic [DATA_WIDTH-1:0]     lat_wdata;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      denied_q;
  logic                      out_of_reset;
  logic                      accept;
  logic                      deny;
  logic                      issuing;
  logic [VIOL_CNT_WIDTH-1:0] viol_inc;

  // out_of_reset keeps req_ready low while rst_n is asserted, so every output is 0 in reset
  assign accept   = (state == IDLE) && out_of_reset && req_valid;
  assign deny     = (req_tid != '0) || locked;
  assign issuing  = (state == ISSUE);
  assign viol_inc = (viol_count == '1) ? viol_count : viol_count + VIOL_CNT_WIDTH'(1);

  assign req_ready     = (state == IDLE) && out_of_reset;
  assign rsp_valid     = (state == RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_denied    = denied_q;
  assign reg_access_en = issuing;
  assign reg_wr_en     = issuing && lat_wr;
  assign reg_thread_id = issuing ? lat_tid : '0;
  assign reg_data_in   = (issuing && lat_wr) ? lat_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = deny ? RESP : ISSUE;
      ISSUE:   state_next = lat_wr ? RESP : WAIT_RD;
      WAIT_RD: state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, response data and violation bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_of_reset <= 1'b0;
      lat_wr       <= 1'b0;
      lat_tid      <= '0;
      lat_wdata    <= '0;
      rdata_q      <= '0;
      denied_q     <= 1'b0;
      viol_count   <= '0;
      viol_flag    <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      if (accept) begin
        lat_wr    <= req_wr;
        lat_tid   <= req_tid;
        lat_wdata <= req_wr ? req_wdata : '0;
        rdata_q   <= '0;
        denied_q  <= deny;
        if (deny) begin
          viol_count <= viol_inc;
          viol_flag  <= 1'b1;
        end
      end
      if (state == WAIT_RD) rdata_q <= reg_data_out;
    end
  end

`ifdef SECREG_LOCKOUT_EN
  localparam logic [VIOL_CNT_WIDTH-1:0] LOCK_TH = VIOL_CNT_WIDTH'(LOCK_THRESHOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  locked <= 1'b0;
    else if (accept && deny && viol_inc >= LOCK_TH) locked <= 1'b1;
  end
`else
  logic unused_lock_threshold;
  assign unused_lock_threshold = (LOCK_THRESHOLD == 0);
  assign locked = 1'b0;
`endif

endmodule

// File: doc/secure_reg_requester.md
Name: secure_reg_requester

Overview:
Initiator-side front end for the thread-gated secure register. It accepts access requests from many threads over a valid/ready interface and enforces the thread_id==0 policy before anything reaches the register bus. Permitted requests are serialized onto the register interface (access_en/wr_en/thread_id/data_in), read data is captured, and every request gets a response carrying a denied status. Denied attempts are counted for the security monitor.

Parameters:
DATA_WIDTH, 32, width of register data and request write/read data
TID_WIDTH, 4, width of thread id
VIOL_CNT_WIDTH, 8, width of saturating violation counter
LOCK_THRESHOLD, 4, violation count that triggers lockout (used only with SECREG_LOCKOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when valid&ready
req_wr  input  1  1=write, 0=read
req_tid  input  TID_WIDTH  requesting thread id
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when valid&ready
rsp_rdata  output  DATA_WIDTH  read data (0 for writes/denied)
rsp_denied  output  1  1=request refused, register untouched
reg_access_en  output  1  register access strobe
reg_wr_en  output  1  register write enable
reg_thread_id  output  TID_WIDTH  thread id presented to register
reg_data_in  output  DATA_WIDTH  write data to register
reg_data_out  input  DATA_WIDTH  read data from register, valid cycle after read strobe
viol_count  output  VIOL_CNT_WIDTH  denied-request count, saturating
viol_flag  output  1  sticky: any denial since reset
locked  output  1  lockout active (constant 0 without macro)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; latched request, viol_count, viol_flag and locked cleared. An in-flight access is dropped with no response. Exit is synchronous to clk.
- All outputs are registered or decoded from state only; there is no combinational path from req_* or rsp_ready to outputs.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE: req_ready=1. On req_valid, latch wr/tid/wdata.
  - tid==0 and not locked: go to ISSUE.
  - Otherwise: go to RESP with denied=1 and rdata=0; viol_count+1 (saturates at all-ones); viol_flag=1.
- ISSUE, exactly one cycle: reg_access_en=1, reg_wr_en=wr, reg_thread_id=tid, reg_data_in=wdata (0 on reads).
  - Write: go to RESP with denied=0, rdata=0.
  - Read: go to WAIT_RD.
- WAIT_RD, one cycle: capture reg_data_out into rsp_rdata, then go to RESP with denied=0.
- RESP: rsp_valid=1; rsp_rdata and rsp_denied are held stable until rsp_ready, then go to IDLE. req_ready=0 outside IDLE (one outstanding request).
- Outside ISSUE, reg_access_en, reg_wr_en, reg_thread_id and reg_data_in are all 0. Denied data never reaches the bus.
- Latency, with the request accepted at edge T:
  - denied: rsp_valid in cycle T+1
  - write: strobe in cycle T+1, rsp_valid in cycle T+2
  - read: strobe in cycle T+1, capture at end of T+2, rsp_valid in cycle T+3
- Back-to-back: after the RESP handshake, the next request can be accepted the following cycle.
- Counter saturation: viol_count at max stays at max; viol_flag stays 1.

Optional Feature:
SECREG_LOCKOUT_EN:
- Defined: when a denial makes viol_count >= LOCK_THRESHOLD, locked=1 sticky until reset. While locked, every request (including tid 0) is denied and counted, and the register bus stays idle.
- Undefined: locked is tied to 0, LOCK_THRESHOLD is ignored, and only tid!=0 requests are denied.

Test Plan:
1. Reset, then write tid=0 data=0xDEADBEEF, then read tid=0 -> strobe with wr_en=1, data_in=0xDEADBEEF at T+1; rsp at T+2 denied=0; read rsp at T+3 rdata=0xDEADBEEF.
2. Write tid=3 data=0x12345678 -> reg_access_en never 1; rsp at T+1 denied=1, rdata=0; viol_count=1; viol_flag=1.
3. Response backpressure: read tid=0 with rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable, req_ready=0 throughout; accept next request the cycle after the handshake.
4. Issue 300 tid=5 requests with VIOL_CNT_WIDTH=8 -> viol_count saturates at 255 and stays there.
5. Assert rst_n low during WAIT_RD -> all outputs 0 immediately; no response after release; viol_count=0.
6. SECREG_LOCKOUT_EN defined, 4 requests with tid=1, then write tid=0 -> locked=1 after the 4th denial; the tid=0 write is denied, no strobe, viol_count=5.
